// File: rtl/vector3_pkg.sv
// Shared constants and types for the vector3 receive-side unpacker.
// The packed word is {a,b,c,d,e,f,marker}, MSB first, 5-bit fields and a 2-bit trailer.
package vector3_pkg;

    localparam int FIELD_W    = 5;
    localparam int NUM_FIELDS = 6;
    localparam int BYTE_W     = 8;
    localparam int WORD_W     = 32;
    localparam int MARKER_W   = 2;

    // LSB position of each field inside the packed word
    localparam int A_LSB      = 27;
    localparam int B_LSB      = 22;
    localparam int C_LSB      = 17;
    localparam int D_LSB      = 12;
    localparam int E_LSB      = 7;
    localparam int F_LSB      = 2;
    localparam int MARKER_LSB = 0;

    // Collector phase: COLLECT while bytes 0..2 are expected, LAST while byte 3 is expected
    typedef enum logic {
        COLLECT = 1'b0,
        LAST    = 1'b1
    } state_t;

endpackage

// File: rtl/vector3_byte_collector.sv
// Byte collector for vector3_unpack: shifts in bytes 0..2, tracks the byte index and
// gates in_ready so the completing byte waits while an undelivered frame is held.
// word/word_done are combinational: the full word is {bytes 0..2, current byte} in the
// cycle the completing byte transfers, so the top level can load it on that same edge.
//
// state   | meaning
// COLLECT | index 0..2; index 0 doubles as idle
// LAST    | index 3; the next accepted byte completes the frame
module vector3_byte_collector
    import vector3_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [BYTE_W-1:0]   in_data,
    input  logic                in_valid,
    input  logic                out_valid,
    input  logic                out_ready,
    output logic                in_ready,
    output logic                word_done,
    output logic [WORD_W-1:0]   word
);

    localparam int COLLECT_W = WORD_W - BYTE_W;

    state_t               state;
    logic [1:0]           index;
    logic [COLLECT_W-1:0] collect;
    logic                 accept;

    // Only the completing byte can stall: an undelivered frame would otherwise be overwritten
    assign in_ready  = !(state == LAST && out_valid && !out_ready);
    assign accept    = in_valid && in_ready;
    assign word_done = accept && (state == LAST);
    assign word      = {collect, in_data};

    // Byte index, phase and shift register advance on every accepted byte
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= COLLECT;
            index   <= 2'd0;
            collect <= '0;
        end else if (accept) begin
            index   <= index + 2'd1;
            collect <= {collect[COLLECT_W-BYTE_W-1:0], in_data};
            state   <= (index == 2'd2) ? LAST : COLLECT;
        end
    end

endmodule

// File: rtl/vector3_unpack.sv
// vector3_unpack: reassembles the six 5-bit fields from a 4-byte packed stream and
// presents them on a registered valid/ready output.
// Optional feature macro: VECTOR3_UNPACK_MARKER_CHECK_EN
//   defined   - trailer compared against MARKER; mismatching frames dropped, frame_err pulses
//   undefined - trailer ignored, every completed frame delivered, frame_err stays 0
module vector3_unpack
    import vector3_pkg::*;
#(
    parameter logic [MARKER_W-1:0] MARKER = 2'b11
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic [BYTE_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [FIELD_W-1:0] a,
    output logic [FIELD_W-1:0] b,
    output logic [FIELD_W-1:0] c,
    output logic [FIELD_W-1:0] d,
    output logic [FIELD_W-1:0] e,
    output logic [FIELD_W-1:0] f,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               frame_err
);

    logic              word_done;
    logic [WORD_W-1:0] word;
    logic              marker_ok;
    logic              frame_ok;
    logic              frame_bad;

    vector3_byte_collector u_collector (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .word_done (word_done),
        .word      (word)
    );

`ifdef VECTOR3_UNPACK_MARKER_CHECK_EN
    assign marker_ok = (word[MARKER_LSB +: MARKER_W] == MARKER);
`else
    // Trailer is still read so both builds use the same word bits; the result is forced true
    assign marker_ok = 1'b1 | (word[MARKER_LSB +: MARKER_W] == MARKER);
`endif

    assign frame_ok  = word_done && marker_ok;
    assign frame_bad = word_done && !marker_ok;

    // Output register: a completing frame wins over the consumer handshake, giving no bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            a         <= '0;
            b         <= '0;
            c         <= '0;
            d         <= '0;
            e         <= '0;
            f         <= '0;
        end else if (frame_ok) begin
            out_valid <= 1'b1;
            a         <= word[A_LSB +: FIELD_W];
            b         <= word[B_LSB +: FIELD_W];
            c         <= word[C_LSB +: FIELD_W];
            d         <= word[D_LSB +: FIELD_W];
            e         <= word[E_LSB +: FIELD_W];
            f         <= word[F_LSB +: FIELD_W];
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Single-cycle error pulse for a dropped frame
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= frame_bad;
        end
    end

endmodule

// File: tb/tb_vector3_unpack.sv
// Bench for vector3_unpack: directed table, hand-written backpressure and reset
// sequences, then randomized traffic checked against a word-level model.
module tb_vector3_unpack;

`ifdef VECTOR3_UNPACK_MARKER_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [4:0] a, b, c, d, e, f;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       frame_err;

    int total = 0;
    int bad   = 0;

    vector3_unpack #(.MARKER(2'b11)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .e         (e),
        .f         (f),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        logic        vld;
        logic [29:0] fields;
        logic        err;
    } vec_t;

    vec_t tbl [5];

    logic [31:0] exp_q [$];
    int          exp_err_cnt = 0;
    int          seen_err    = 0;
    bit          mon_en      = 1'b0;
    bit          hold_prev   = 1'b0;
    logic [29:0] prev_fields = '0;
    bit          drv_done    = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Field extraction from the packed-word definition: 5-bit slices from bit 27 down
    function automatic logic [29:0] decode(input logic [31:0] w);
        logic [29:0] r;
        longint unsigned v;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            v = (longint'(w) / (64'd1 << (27 - 5 * i))) % 32;
            r = (r << 5) | 30'(v);
        end
        return r;
    endfunction

    function automatic logic [29:0] fields_now();
        return {a, b, c, d, e, f};
    endfunction

    // Called at #1 after an edge; returns at #1 after the edge that accepted the byte
    task automatic send_byte(input logic [7:0] bt, input int gap);
        logic r;
        int   n;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = bt;
        r = 1'b0;
        n = 0;
        while (!r && n < 50) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            n++;
        end
        #1;
        in_valid = 1'b0;
        if (!r) chk("byte_accept_timeout", 32'(r), 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int i = 0; i < 4; i++)
            send_byte(w[31 - 8 * i -: 8], $urandom_range(0, maxgap));
    endtask

    // Scoreboard for the randomized phase
    always @(negedge clk) begin
        if (mon_en) begin
            if (hold_prev) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_fields", {2'b0, fields_now()}, {2'b0, prev_fields});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0)
                    chk("unexpected_frame", {2'b0, fields_now()}, 32'hFFFF_FFFF);
                else
                    chk("rand_fields", {2'b0, fields_now()}, {2'b0, decode(exp_q.pop_front())});
            end
            if (frame_err) seen_err++;
            hold_prev   = out_valid && !out_ready;
            prev_fields = fields_now();
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: sim time limit reached, expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{32'h0044_3217, 1'b1, {5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5}, 1'b0};
        tbl[1] = '{32'hFA9F_0AEF, 1'b1, {5'h1F, 5'h0A, 5'h0F, 5'h10, 5'h15, 5'h1B}, 1'b0};
        tbl[2] = '{32'h0044_3214, !CHK, {5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5}, CHK};
        tbl[3] = '{32'hFFFF_FFFF, 1'b1, {6{5'h1F}}, 1'b0};
        tbl[4] = '{32'h0000_0003, 1'b1, 30'd0, 1'b0};

        // Reset values
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_fields", {2'b0, fields_now()}, 32'd0);
        @(posedge clk);
        #1;

        // Table: one frame each with out_ready held high
        for (int i = 0; i < 5; i++) begin
            out_ready = 1'b1;
            send_word(tbl[i].word, 3);
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].vld));
            chk($sformatf("tbl%0d_err", i), 32'(frame_err), 32'(tbl[i].err));
            if (tbl[i].vld)
                chk($sformatf("tbl%0d_fields", i), {2'b0, fields_now()}, {2'b0, tbl[i].fields});
            @(negedge clk);
            chk($sformatf("tbl%0d_valid_clear", i), 32'(out_valid), 32'd0);
            chk($sformatf("tbl%0d_err_clear", i), 32'(frame_err), 32'd0);
            @(posedge clk);
            #1;
        end

        // Backpressure: first frame held, completing byte of second frame stalls
        out_ready = 1'b0;
        send_word(32'h0044_3217, 0);
        @(negedge clk);
        chk("bp_first_valid", 32'(out_valid), 32'd1);
        chk("bp_first_fields", {2'b0, fields_now()}, {2'b0, 5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5});
        @(posedge clk);
        #1;
        send_byte(8'hFA, 0);
        send_byte(8'h9F, 0);
        send_byte(8'h0A, 0);
        in_valid = 1'b1;
        in_data  = 8'hEF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_stall_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_fields", {2'b0, fields_now()}, {2'b0, 5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_second_valid", 32'(out_valid), 32'd1);
        chk("bp_second_fields", {2'b0, fields_now()},
            {2'b0, 5'h1F, 5'h0A, 5'h0F, 5'h10, 5'h15, 5'h1B});
        @(negedge clk);
        chk("bp_second_clear", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Reset in the middle of a frame
        send_byte(8'hFA, 0);
        send_byte(8'h9F, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_frame_err", 32'(frame_err), 32'd0);
        chk("mid_rst_fields", {2'b0, fields_now()}, 32'd0);
        @(posedge clk);
        #1;
        send_word(32'h0044_3217, 0);
        @(negedge clk);
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_err", 32'(frame_err), 32'd0);
        chk("post_rst_fields", {2'b0, fields_now()}, {2'b0, 5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5});
        @(negedge clk);
        @(posedge clk);
        #1;

        // Randomized traffic with random gaps, markers and consumer backpressure
        mon_en = 1'b1;
        fork
            begin
                for (int n = 0; n < 60; n++) begin
                    logic [31:0] w;
                    w = $urandom;
                    if ($urandom_range(0, 3) == 0) w[1:0] = 2'($urandom_range(0, 2));
                    else                          w[1:0] = 2'b11;
                    send_word(w, 2);
                    if (!CHK || w[1:0] == 2'b11) exp_q.push_back(w);
                    else                         exp_err_cnt++;
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        mon_en = 1'b0;
        chk("rand_drain_empty", 32'(exp_q.size()), 32'd0);
        chk("rand_err_count", 32'(seen_err), 32'(exp_err_cnt));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
